// File: rtl/freelist.sv
// Circular list of free physical register tags feeding the rename stage.
// Optional macro FREELIST_BYPASS_EN forwards a retiring tag straight to dispatch when the list is empty.
module freelist #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    localparam int PW    = $clog2(PHYS_REG_SZ),
    localparam int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ,
    localparam int HW    = $clog2(FL_SZ),
    localparam int CW    = $clog2(FL_SZ) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dispatch_en,
    input  logic          retire_en,
    input  logic [PW-1:0] retire_t_old,
    output logic [PW-1:0] t_out,
    output logic          t_out_valid,
    output logic [CW-1:0] free_cnt,
    output logic          overflow_err
);

    logic [PW-1:0] entries [FL_SZ];
    logic [HW-1:0] head;
    logic [HW-1:0] tail;
    logic [CW-1:0] count;

    logic empty;
    logic full;
    logic pop_done;
    logic push_done;
    logic push_drop;

    function automatic logic [HW-1:0] next_ptr(input logic [HW-1:0] p);
        return (p == HW'(FL_SZ - 1)) ? '0 : p + 1'b1;
    endfunction

    // count alone decides full/empty; head == tail is ambiguous
    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(FL_SZ));
        pop_done  = dispatch_en && !empty;
        push_drop = retire_en && full && !dispatch_en;
`ifdef FREELIST_BYPASS_EN
        push_done = retire_en && (!full || dispatch_en) && !(empty && dispatch_en);
        if (empty && retire_en) begin
            t_out       = retire_t_old;
            t_out_valid = 1'b1;
        end else begin
            t_out       = entries[head];
            t_out_valid = !empty;
        end
`else
        push_done   = retire_en && (!full || dispatch_en);
        t_out       = entries[head];
        t_out_valid = !empty;
`endif
    end

    assign free_cnt = count;

    // When full, a simultaneous pop frees the head slot, which is the one tail overwrites
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SZ; i++) begin
                entries[i] <= PW'(ARCH_REG_SZ + i);
            end
            head         <= '0;
            tail         <= '0;
            count        <= CW'(FL_SZ);
            overflow_err <= 1'b0;
        end else begin
            if (push_done) begin
                entries[tail] <= retire_t_old;
                tail          <= next_ptr(tail);
            end
            if (pop_done) begin
                head <= next_ptr(head);
            end
            count <= count + CW'(push_done) - CW'(pop_done);
            if (push_drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: queue model of the free list plus a scoreboard of dispatched tags.
module tb_freelist;

    localparam int PW = 6;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dispatch_en = 1'b0;
    logic          retire_en = 1'b0;
    logic [PW-1:0] retire_t_old = '0;
    logic [PW-1:0] t_out;
    logic          t_out_valid;
    logic [CW-1:0] free_cnt;
    logic          overflow_err;

    int tests = 0;
    int fails = 0;

    int mdl[$];
    int exp_q[$];
    bit mdl_ovf;
    logic [PW-1:0] obs_t_out;
    logic          obs_valid;

`ifdef FREELIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    freelist #(.PHYS_REG_SZ(64), .ARCH_REG_SZ(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .dispatch_en  (dispatch_en),
        .retire_en    (retire_en),
        .retire_t_old (retire_t_old),
        .t_out        (t_out),
        .t_out_valid  (t_out_valid),
        .free_cnt     (free_cnt),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mdl.delete();
        for (int i = 0; i < 32; i++) mdl.push_back(32 + i);
        mdl_ovf = 1'b0;
    endtask

    task automatic do_reset(input logic d, input logic r);
        @(negedge clock);
        reset = 1'b1; dispatch_en = d; retire_en = r; retire_t_old = 6'd1;
        @(posedge clock);
        #1;
        reset = 1'b0; dispatch_en = 1'b0; retire_en = 1'b0;
        model_reset();
    endtask

    // One cycle of stimulus: check outputs against the model, then advance the model
    task automatic drive(input logic d, input logic r, input logic [PW-1:0] tag);
        bit pop, push, full, empty, pass;
        int exp_tag;
        @(negedge clock);
        dispatch_en = d; retire_en = r; retire_t_old = tag;
        #1;
        obs_t_out = t_out;
        obs_valid = t_out_valid;
        empty = (mdl.size() == 0);
        full  = (mdl.size() == 32);
        pass  = BYP && empty && r && d;
        pop   = d && !empty;
        push  = r && (!full || d) && !pass;
        if (pop) exp_q.push_back(mdl[0]);
        else if (pass) exp_q.push_back(int'(tag));
        tests++;
        if (t_out_valid !== (!empty || (BYP && r))) begin
            fails++;
            $display("FAIL valid: got %0b want %0b", t_out_valid, (!empty || (BYP && r)));
        end
        tests++;
        if (free_cnt !== CW'(mdl.size())) begin
            fails++;
            $display("FAIL free_cnt: got %0d want %0d", free_cnt, mdl.size());
        end
        tests++;
        if (overflow_err !== mdl_ovf) begin
            fails++;
            $display("FAIL overflow_err: got %0b want %0b", overflow_err, mdl_ovf);
        end
        if (exp_q.size() != 0) begin
            exp_tag = exp_q.pop_front();
            tests++;
            if (t_out !== PW'(exp_tag)) begin
                fails++;
                $display("FAIL dispatch_tag: got %0d want %0d", t_out, exp_tag);
            end
        end
        if (pop) void'(mdl.pop_front());
        if (push) mdl.push_back(int'(tag));
        if (r && full && !d) mdl_ovf = 1'b1;
        @(posedge clock);
        #1;
        dispatch_en = 1'b0; retire_en = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        check("reset_t_out", int'(t_out), 32);
        check("reset_valid", int'(t_out_valid), 1);
        check("reset_free_cnt", int'(free_cnt), 32);
        check("reset_ovf", int'(overflow_err), 0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, '0);
            check("drain_step", int'(obs_t_out), 32 + i);
        end
        check("drain_free_cnt", int'(free_cnt), 0);
        check("drain_valid", int'(t_out_valid), 0);
        drive(1'b1, 1'b0, '0);
        check("pop_empty_free_cnt", int'(free_cnt), 0);
    endtask

    task automatic test_refill();
        drive(1'b0, 1'b1, 6'd5);
        drive(1'b0, 1'b1, 6'd9);
        check("refill_free_cnt", int'(free_cnt), 2);
        check("refill_t_out", int'(t_out), 5);
        drive(1'b1, 1'b0, '0);
        check("refill_after_pop", int'(t_out), 9);
        drive(1'b1, 1'b0, '0);
    endtask

    task automatic test_overflow();
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b1, 6'd7);
        check("ovf_set", int'(overflow_err), 1);
        check("ovf_free_cnt", int'(free_cnt), 32);
        drive(1'b1, 1'b1, 6'd7);
        check("full_pp_ovf", int'(overflow_err), 1);
        check("full_pp_free_cnt", int'(free_cnt), 32);
        for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, '0);
        check("full_pp_tag7", int'(t_out), 7);
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b0, '0);
        check("byp_empty", int'(free_cnt), 0);
        drive(1'b1, 1'b1, 6'd12);
        if (BYP) begin
            check("byp_t_out", int'(obs_t_out), 12);
            check("byp_valid", int'(obs_valid), 1);
            check("byp_free_cnt", int'(free_cnt), 0);
        end else begin
            check("nobyp_valid", int'(obs_valid), 0);
            check("nobyp_free_cnt", int'(free_cnt), 1);
            check("nobyp_t_out", int'(t_out), 12);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, PW'(i + 1));
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, PW'(i + 20));
        drive(1'b0, 1'b1, 6'd30);
        drive(1'b0, 1'b1, 6'd31);
        drive(1'b0, 1'b1, 6'd33);
        drive(1'b0, 1'b1, 6'd34);
        drive(1'b0, 1'b1, 6'd35);
        check("mid_free_cnt", int'(free_cnt), 10);
        do_reset(1'b1, 1'b1);
        check("mid_reset_free_cnt", int'(free_cnt), 32);
        check("mid_reset_t_out", int'(t_out), 32);
        check("mid_reset_ovf", int'(overflow_err), 0);
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom_range(0, 63)));
        end
        // drain then refill to exercise the empty edge repeatedly
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom_range(0, 63)));
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_refill();
        test_overflow();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
